// File: rtl/score_pkg.sv
// Shared types and default sizing for the score/level tracker.
package score_pkg;

  typedef enum logic [0:0] {
    PLAY = 1'b0,
    OVER = 1'b1
  } state_e;

  localparam int SCORE_W_DEF          = 16;
  localparam int BONUS_W_DEF          = 4;
  localparam int LEVEL_W_DEF          = 4;
  localparam int POINTS_PER_LEVEL_DEF = 4;
  localparam int MAX_LEVEL_DEF        = 9;

endpackage

// File: rtl/score_level_tracker_rise_detect.sv
// Rising-edge detector: registers the input every cycle and flags 0->1 transitions.
module rise_detect (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic rise
);

  logic d_r;

  // previous-cycle sample of d
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      d_r <= 1'b0;
    end else begin
      d_r <= d;
    end
  end

  assign rise = d & ~d_r;

endmodule

// File: rtl/score_level_tracker.sv
// Game score unit: saturating score, capped level with catch-up pulses,
// and a high score latched at game over that survives new games.
module score_level_tracker
  import score_pkg::*;
#(
  parameter int SCORE_W          = SCORE_W_DEF,
  parameter int BONUS_W          = BONUS_W_DEF,
  parameter int LEVEL_W          = LEVEL_W_DEF,
  parameter int POINTS_PER_LEVEL = POINTS_PER_LEVEL_DEF,
  parameter int MAX_LEVEL        = MAX_LEVEL_DEF
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               clr,
  input  logic               gameover,
  input  logic               eat,
  input  logic [BONUS_W-1:0] bonus,
  output logic [SCORE_W-1:0] score,
  output logic [LEVEL_W-1:0] level,
  output logic               levelup,
  output logic [SCORE_W-1:0] high_score,
  output logic               new_high,
  output logic               saturated,
  output logic               over
);

  localparam int SW1 = SCORE_W + 1;
  localparam int SW2 = SCORE_W + 2;

  state_e             state_r, state_s;
  logic [SCORE_W-1:0] score_r, score_s;
  logic [LEVEL_W-1:0] level_r, level_s;
  logic [SCORE_W:0]   thr_r, thr_s;
  logic [SCORE_W-1:0] high_r, high_s;
  logic               new_high_r, new_high_s;
  logic               sat_r, sat_s;
  logic               levelup_r, levelup_s;
  logic               eat_rise_s;
  logic [SCORE_W:0]   sum_s;
  logic [SCORE_W+1:0] thr_sum_s;
  logic [SCORE_W:0]   thr_next_s;

  rise_detect u_rise (
    .clk  (clk),
    .rst  (rst),
    .d    (eat),
    .rise (eat_rise_s)
  );

  // One extra bit on the sum exposes overflow; threshold clamps instead of wrapping
  assign sum_s      = {1'b0, score_r} + SW1'(bonus) + SW1'(1);
  assign thr_sum_s  = {1'b0, thr_r} + SW2'(POINTS_PER_LEVEL);
  assign thr_next_s = thr_sum_s[SCORE_W+1] ? {SW1{1'b1}} : thr_sum_s[SCORE_W:0];

  // next-state and datapath decisions; clr outranks gameover outranks eat
  always_comb begin
    state_s    = state_r;
    score_s    = score_r;
    level_s    = level_r;
    thr_s      = thr_r;
    high_s     = high_r;
    new_high_s = new_high_r;
    sat_s      = sat_r;
    levelup_s  = 1'b0;
    if (clr) begin
      state_s    = PLAY;
      score_s    = {SCORE_W{1'b0}};
      level_s    = {LEVEL_W{1'b0}};
      thr_s      = SW1'(POINTS_PER_LEVEL);
      new_high_s = 1'b0;
      sat_s      = 1'b0;
    end else begin
      case (state_r)
        PLAY: begin
          if (gameover) begin
            state_s = OVER;
            if (score_r > high_r) begin
              high_s     = score_r;
              new_high_s = 1'b1;
            end else begin
              high_s = high_r;
            end
          end else begin
            if (eat_rise_s) begin
              if (sum_s[SCORE_W]) begin
                score_s = {SCORE_W{1'b1}};
                sat_s   = 1'b1;
              end else begin
                score_s = sum_s[SCORE_W-1:0];
              end
            end else begin
              score_s = score_r;
            end
            // level follows the registered score one step per cycle
            if ((level_r < LEVEL_W'(MAX_LEVEL)) && ({1'b0, score_r} >= thr_r)) begin
              level_s   = level_r + LEVEL_W'(1);
              thr_s     = thr_next_s;
              levelup_s = 1'b1;
            end else begin
              level_s = level_r;
            end
          end
        end
        OVER: begin
          state_s = OVER;
        end
        default: begin
          state_s = PLAY;
        end
      endcase
    end
  end

  // state and output registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r    <= PLAY;
      score_r    <= {SCORE_W{1'b0}};
      level_r    <= {LEVEL_W{1'b0}};
      thr_r      <= SW1'(POINTS_PER_LEVEL);
      high_r     <= {SCORE_W{1'b0}};
      new_high_r <= 1'b0;
      sat_r      <= 1'b0;
      levelup_r  <= 1'b0;
    end else begin
      state_r    <= state_s;
      score_r    <= score_s;
      level_r    <= level_s;
      thr_r      <= thr_s;
      high_r     <= high_s;
      new_high_r <= new_high_s;
      sat_r      <= sat_s;
      levelup_r  <= levelup_s;
    end
  end

  assign score      = score_r;
  assign level      = level_r;
  assign levelup    = levelup_r;
  assign high_score = high_r;
  assign new_high   = new_high_r;
  assign saturated  = sat_r;
  assign over       = (state_r == OVER);

endmodule

// File: tb/tb_score_level_tracker.sv
// Bench for score_level_tracker: directed vector table, hand sequences, and
// randomized traffic on a 16-bit and a 4-bit score instance against a model.
module tb_score_level_tracker;

  localparam int PPL  = 4;
  localparam int MAXL = 9;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       clr = 1'b0;
  logic       gameover = 1'b0;
  logic       eat = 1'b0;
  logic [3:0] bonus = 4'd0;

  logic [15:0] score, high_score;
  logic [3:0]  level;
  logic        levelup, new_high, saturated, over;
  logic [3:0]  s_score, s_high;
  logic [3:0]  s_level;
  logic        s_levelup, s_new_high, s_saturated, s_over;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  score_level_tracker dut (
    .clk(clk), .rst(rst), .clr(clr), .gameover(gameover), .eat(eat), .bonus(bonus),
    .score(score), .level(level), .levelup(levelup), .high_score(high_score),
    .new_high(new_high), .saturated(saturated), .over(over)
  );

  score_level_tracker #(.SCORE_W(4)) dut_s (
    .clk(clk), .rst(rst), .clr(clr), .gameover(gameover), .eat(eat), .bonus(bonus),
    .score(s_score), .level(s_level), .levelup(s_levelup), .high_score(s_high),
    .new_high(s_new_high), .saturated(s_saturated), .over(s_over)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // one clock: drive inputs, take the edge, settle
  task automatic step(input bit c, input bit g, input bit e, input int b);
    clr = c; gameover = g; eat = e; bonus = 4'(b);
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    bit c, g, e; int b;
    int score, level; bit lu, ov, nh; int high;
  } vec_t;
  vec_t vq[$];

  task automatic add(input bit c, input bit g, input bit e, input int b, input int s,
                     input int l, input bit lu, input bit ov, input bit nh, input int h);
    vec_t v;
    v = '{c:c, g:g, e:e, b:b, score:s, level:l, lu:lu, ov:ov, nh:nh, high:h};
    vq.push_back(v);
  endtask

  // Behavioural model: level target is simply score/PPL, approached one step per cycle
  typedef struct {
    bit play; int score, level, high; bit new_high, sat, levelup, eat_d;
  } mdl_t;

  function automatic mdl_t mstep(mdl_t m, int smax, bit c, bit g, bit e, int b);
    mdl_t n = m;
    n.eat_d = e;
    n.levelup = 1'b0;
    if (c) begin
      n.play = 1'b1; n.score = 0; n.level = 0; n.sat = 1'b0; n.new_high = 1'b0;
    end else if (m.play) begin
      if (g) begin
        n.play = 1'b0;
        if (m.score > m.high) begin n.high = m.score; n.new_high = 1'b1; end
      end else begin
        if (e && !m.eat_d) begin
          if (m.score + 1 + b > smax) begin n.score = smax; n.sat = 1'b1; end
          else n.score = m.score + 1 + b;
        end
        if (m.level < MAXL && m.level < m.score / PPL) begin
          n.level = m.level + 1; n.levelup = 1'b1;
        end
      end
    end
    return n;
  endfunction

  function automatic mdl_t mreset();
    mdl_t m;
    m = '{play:1'b1, score:0, level:0, high:0, new_high:1'b0, sat:1'b0, levelup:1'b0, eat_d:1'b0};
    return m;
  endfunction

  mdl_t m_big, m_small;

  initial begin
    // reset state
    repeat (2) @(posedge clk);
    #1;
    chk("rst_score", 32'(score), 32'd0);
    chk("rst_level", 32'(level), 32'd0);
    chk("rst_over", 32'(over), 32'd0);
    chk("rst_high", 32'(high_score), 32'd0);
    rst = 1'b0;

    // single edges, held eat, multi-threshold bonus, game over, combined clr
    add(0,0,0,0, 0,0,0,0,0,0);
    add(0,0,1,0, 1,0,0,0,0,0);
    add(0,0,0,0, 1,0,0,0,0,0);
    add(0,0,1,0, 2,0,0,0,0,0);
    add(0,0,0,0, 2,0,0,0,0,0);
    add(0,0,1,0, 3,0,0,0,0,0);
    add(0,0,0,0, 3,0,0,0,0,0);
    add(0,0,1,0, 4,0,0,0,0,0);
    add(0,0,0,0, 4,1,1,0,0,0);
    for (int i = 0; i < 10; i++) add(0,0,1,0, 5,1,0,0,0,0);
    add(0,0,0,0, 5,1,0,0,0,0);
    add(1,0,0,0, 0,0,0,0,0,0);
    add(0,0,1,2, 3,0,0,0,0,0);
    add(0,0,0,0, 3,0,0,0,0,0);
    add(0,0,1,8, 12,0,0,0,0,0);
    add(0,0,0,0, 12,1,1,0,0,0);
    add(0,0,0,0, 12,2,1,0,0,0);
    add(0,0,0,0, 12,3,1,0,0,0);
    add(0,0,0,0, 12,3,0,0,0,0);
    add(0,1,0,0, 12,3,0,1,1,12);
    add(0,0,1,0, 12,3,0,1,1,12);
    add(0,0,0,0, 12,3,0,1,1,12);
    add(1,1,1,0, 0,0,0,0,0,12);
    add(0,0,1,0, 0,0,0,0,0,12);
    add(0,1,0,0, 0,0,0,1,0,12);
    add(1,0,0,0, 0,0,0,0,0,12);

    foreach (vq[i]) begin
      step(vq[i].c, vq[i].g, vq[i].e, vq[i].b);
      chk($sformatf("vec%0d_score", i), 32'(score), 32'(vq[i].score));
      chk($sformatf("vec%0d_level", i), 32'(level), 32'(vq[i].level));
      chk($sformatf("vec%0d_levelup", i), 32'(levelup), 32'(vq[i].lu));
      chk($sformatf("vec%0d_over", i), 32'(over), 32'(vq[i].ov));
      chk($sformatf("vec%0d_new_high", i), 32'(new_high), 32'(vq[i].nh));
      chk($sformatf("vec%0d_high", i), 32'(high_score), 32'(vq[i].high));
    end

    // saturation on the 4-bit instance: 14 + 6 clips to 15
    step(0,0,1,13); step(0,0,0,0);
    chk("sat_pre_score", 32'(s_score), 32'd14);
    chk("sat_pre_flag", 32'(s_saturated), 32'd0);
    step(0,0,1,5); step(0,0,0,0);
    chk("sat_score", 32'(s_score), 32'd15);
    chk("sat_flag", 32'(s_saturated), 32'd1);
    step(0,0,1,0); step(0,0,0,0);
    chk("sat_hold_score", 32'(s_score), 32'd15);
    chk("sat_hold_flag", 32'(s_saturated), 32'd1);
    chk("wide_score", 32'(score), 32'd21);
    chk("wide_nosat", 32'(saturated), 32'd0);

    // asynchronous reset between edges clears everything at once
    #2 rst = 1'b1;
    #1;
    chk("arst_score", 32'(score), 32'd0);
    chk("arst_level", 32'(level), 32'd0);
    chk("arst_high", 32'(high_score), 32'd0);
    chk("arst_s_score", 32'(s_score), 32'd0);
    chk("arst_s_sat", 32'(s_saturated), 32'd0);
    chk("arst_over", 32'(over), 32'd0);
    chk("arst_levelup", 32'(levelup), 32'd0);
    @(negedge clk);
    rst = 1'b0;

    // high score survives a new game and is not lowered
    step(0,0,1,6); step(0,0,0,0);
    chk("hs_score7", 32'(score), 32'd7);
    step(0,1,0,0);
    chk("hs_over", 32'(over), 32'd1);
    chk("hs_high7", 32'(high_score), 32'd7);
    chk("hs_new1", 32'(new_high), 32'd1);
    step(0,0,0,0);
    chk("hs_stay_over", 32'(over), 32'd1);
    step(1,0,0,0);
    chk("hs_clr_score", 32'(score), 32'd0);
    chk("hs_clr_high", 32'(high_score), 32'd7);
    chk("hs_clr_new", 32'(new_high), 32'd0);
    step(0,0,1,4); step(0,0,0,0);
    chk("hs_score5", 32'(score), 32'd5);
    step(0,1,0,0);
    chk("hs_keep_high", 32'(high_score), 32'd7);
    chk("hs_new0", 32'(new_high), 32'd0);

    // randomized traffic against the model on both widths
    rst = 1'b1;
    #3;
    rst = 1'b0;
    m_big = mreset();
    m_small = mreset();
    for (int i = 0; i < 2000; i++) begin
      bit c, g, e; int b;
      c = ($urandom_range(0, 99) < 4);
      g = ($urandom_range(0, 99) < 3);
      e = $urandom_range(0, 1) == 1;
      b = (($urandom_range(0, 3) == 0) ? $urandom_range(0, 15) : $urandom_range(0, 2));
      m_big = mstep(m_big, 65535, c, g, e, b);
      m_small = mstep(m_small, 15, c, g, e, b);
      step(c, g, e, b);
      chk("rnd_score", 32'(score), 32'(m_big.score));
      chk("rnd_level", 32'(level), 32'(m_big.level));
      chk("rnd_levelup", 32'(levelup), 32'(m_big.levelup));
      chk("rnd_high", 32'(high_score), 32'(m_big.high));
      chk("rnd_new_high", 32'(new_high), 32'(m_big.new_high));
      chk("rnd_sat", 32'(saturated), 32'(m_big.sat));
      chk("rnd_over", 32'(over), 32'(!m_big.play));
      chk("rnd_s_score", 32'(s_score), 32'(m_small.score));
      chk("rnd_s_level", 32'(s_level), 32'(m_small.level));
      chk("rnd_s_levelup", 32'(s_levelup), 32'(m_small.levelup));
      chk("rnd_s_high", 32'(s_high), 32'(m_small.high));
      chk("rnd_s_new_high", 32'(s_new_high), 32'(m_small.new_high));
      chk("rnd_s_sat", 32'(s_saturated), 32'(m_small.sat));
      chk("rnd_s_over", 32'(s_over), 32'(!m_small.play));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/score_level_tracker.md
Name: score_level_tracker

Overview:
Parametrised game score unit with level progression and high-score retention. Counts scoring events with optional bonus points, saturates, derives a capped level with one-cycle level-up pulses, and latches a high score at game over that survives new games. Sits between the game-logic event outputs and the score/level display and speed-control blocks; fully synchronous to clk.

Parameters:
SCORE_W, 16, score and high-score width in bits
BONUS_W, 4, width of bonus input; points per event = 1 + bonus
LEVEL_W, 4, level output width
POINTS_PER_LEVEL, 4, score step between levels (>=1)
MAX_LEVEL, 9, level ceiling (must fit LEVEL_W)

Ports:
clk  in  1  system clock
rst  in  1  reset, asynchronous, active-high
clr  in  1  synchronous new-game request (level)
gameover  in  1  game-over indication (level)
eat  in  1  scoring event, synchronous level; rising edge counts
bonus  in  BONUS_W  extra points, sampled with the eat edge
score  out  SCORE_W  current score
level  out  LEVEL_W  current level
levelup  out  1  one-cycle pulse per level step
high_score  out  SCORE_W  best score since rst
new_high  out  1  last game set a new high score
saturated  out  1  sticky; score hit all-ones
over  out  1  1 in OVER state

Behaviour:
- rst: state PLAY; score, level, high_score, eat_d = 0; levelup, new_high, saturated = 0; threshold = POINTS_PER_LEVEL.
- FSM PLAY/OVER. Priority per cycle: clr > gameover > eat.
- clr (either state): next cycle PLAY, score=0, level=0, threshold=POINTS_PER_LEVEL, saturated=0, new_high=0, levelup=0; high_score kept. eat edge same cycle ignored.
- PLAY, gameover=1: next cycle OVER; if score > high_score then high_score<=score, new_high<=1; else unchanged. eat edge same cycle ignored.
- OVER: score, level frozen, levelup=0, eat ignored; leaves only via clr (gameover deassert alone does nothing).
- eat edge: eat=1 and eat_d=0; eat_d registered every cycle in all states. Holding eat high counts once.
- PLAY edge: score <= score + 1 + bonus (zero-extended, computed SCORE_W+1 bits); if sum > 2^SCORE_W-1, score = all-ones, saturated<=1. Score visible the cycle after the edge.
- Level catch-up: each PLAY cycle, if level < MAX_LEVEL and score >= threshold: level+1, threshold += POINTS_PER_LEVEL (threshold SCORE_W+1 bits, no wrap), levelup=1 that cycle. At most one step per cycle; a large bonus crossing k thresholds gives k consecutive pulses. Catch-up stops on gameover/clr.
- level never exceeds MAX_LEVEL; no levelup at ceiling.
- Outputs registered; no combinational input-to-output path.

Decomposition:
- Package score_pkg: state enum (PLAY, OVER), default parameter constants.
- Sub-module rise_detect (eat_d register + edge pulse); rest in one module.

Test Plan:
- rst, 5 single eat edges bonus=0 -> score 1..5, level 1 at score 4, one levelup pulse.
- eat held high 10 cycles -> score +1 only.
- score=3, eat with bonus=8 (POINTS_PER_LEVEL=4) -> score 12, levelup pulses 3 consecutive cycles, level 3.
- SCORE_W=4, score 14, eat bonus=5 -> score 15, saturated=1; further eats keep 15.
- score 7, gameover -> over=1, high_score 7, new_high=1; clr -> score 0, high_score 7; reach 5, gameover -> high_score 7, new_high=0.
- clr, gameover, eat edge same cycle -> PLAY, score 0; async rst mid-game -> all outputs 0 immediately.
